// File: rtl/exc3_to_bcd_packer_pkg.sv
// Shared constants and state type for the Excess-3 to packed-BCD packer.
package exc3_to_bcd_packer_pkg;

    localparam int DIGITS = 4;
    localparam int ACC_W  = DIGITS * 4;

    localparam logic [3:0] EXC3_OFFSET = 4'd3;
    localparam logic [3:0] CODE_MIN    = 4'b0011;
    localparam logic [3:0] CODE_MAX    = 4'b1100;

    // Digit count held just before the word-filling digit arrives.
    localparam logic [2:0] CNT_LAST = 3'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/exc3_digit_dec.sv
// Maps one Excess-3 code to a BCD digit; out-of-range codes decode to 0 and flag invalid.
module exc3_digit_dec
    import exc3_to_bcd_packer_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [3:0] bcd_o,
    output logic       inv_o
);

    always_comb begin
        inv_o = (code_i < CODE_MIN) || (code_i > CODE_MAX);
        bcd_o = inv_o ? 4'd0 : (code_i - EXC3_OFFSET);
    end

endmodule

// File: rtl/exc3_to_bcd_packer.sv
// Packs a stream of Excess-3 digits (MSD first) into right-aligned BCD words of up to 4 digits.
//
// state    | meaning
// ST_IDLE  | no digits held, accepting
// ST_ACCUM | 1..3 digits held, accepting
// ST_HOLD  | completed word presented on out_*, input stalled
module exc3_to_bcd_packer
    import exc3_to_bcd_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_digit,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_bcd,
    output logic [2:0]        out_count,
    output logic              out_err
);

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [ACC_W-1:0]   out_bcd_q;
    logic [2:0]         out_count_q;
    logic               out_err_q;

    logic [3:0]         dig_bcd;
    logic               dig_inv;
    logic               accept;
    logic               complete;

    exc3_digit_dec u_dec (
        .code_i (in_digit),
        .bcd_o  (dig_bcd),
        .inv_o  (dig_inv)
    );

    always_comb begin
        acc_d    = {acc_q[ACC_W-5:0], dig_bcd};
        cnt_d    = cnt_q + 3'd1;
        err_d    = err_q | dig_inv;
        accept   = in_valid & in_ready_q;
        complete = in_last | (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_count_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        err_q <= err_d;
                        if (complete) begin
                            state_q     <= ST_HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_bcd_q   <= acc_d;
                            out_count_q <= cnt_d;
                            out_err_q   <= err_d;
                        end else begin
                            state_q <= ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    // in_ready returns only after the word is gone, never in the handoff cycle.
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        err_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_bcd_q   <= '0;
                        out_count_q <= '0;
                        out_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;
    assign out_count = out_count_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_exc3_to_bcd_packer.sv
// Directed-vector bench for exc3_to_bcd_packer with hand-computed expected words.
module tb_exc3_to_bcd_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_digit;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic [2:0]  out_count;
    logic        out_err;

    int errors = 0;
    int checks = 0;
    int words  = 0;
    int w0;

    exc3_to_bcd_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid && out_ready) words <= words + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_digit = d;
        in_last  = last;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Call right after the completing push: one cycle later the word must be up.
    task automatic expect_word(input string tag, input logic [15:0] bcd,
                               input logic [2:0] cnt, input logic err);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_bcd"},   32'(out_bcd),   32'(bcd));
        chk({tag, "_count"}, 32'(out_count), 32'(cnt));
        chk({tag, "_err"},   32'(out_err),   32'(err));
        chk({tag, "_rdy"},   32'(in_ready),  32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_digit  = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid_hi", 32'(out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);
        chk("rst_bcd",   32'(out_bcd),   32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_err",   32'(out_err),   32'd0);

        // 4,5,6,7 -> 1234, completes on 4th digit without in_last
        push(4'b0100, 1'b0);
        push(4'b0101, 1'b0);
        push(4'b0110, 1'b0);
        @(negedge clk);
        chk("w1234_early", 32'(out_valid), 32'd0);
        push(4'b0111, 1'b0);
        expect_word("w1234", 16'h1234, 3'd4, 1'b0);
        @(negedge clk);
        chk("w1234_gone",  32'(out_valid), 32'd0);
        chk("w1234_ready", 32'(in_ready),  32'd1);

        push(4'b1100, 1'b0);
        push(4'b0011, 1'b1);
        expect_word("w0090", 16'h0090, 3'd2, 1'b0);

        push(4'b0011, 1'b0);
        push(4'b1111, 1'b0);
        push(4'b0100, 1'b1);
        expect_word("w_err", 16'h0001, 3'd3, 1'b1);

        push(4'b1100, 1'b1);
        expect_word("w0009", 16'h0009, 3'd1, 1'b0);

        // in_last on the 4th digit makes exactly one word
        @(negedge clk);
        w0 = words;
        push(4'b0100, 1'b0);
        push(4'b0101, 1'b0);
        push(4'b0110, 1'b0);
        push(4'b1100, 1'b1);
        expect_word("w1239", 16'h1239, 3'd4, 1'b0);
        repeat (3) @(negedge clk);
        chk("w1239_once", 32'(words - w0), 32'd1);

        // back-pressure: word held 5 cycles while other digits are offered
        out_ready = 1'b0;
        push(4'b0100, 1'b0);
        push(4'b0101, 1'b0);
        push(4'b0110, 1'b0);
        push(4'b0111, 1'b0);
        in_valid = 1'b1;
        in_digit = 4'b1000;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_bcd",   32'(out_bcd),   32'h1234);
            chk("hold_count", 32'(out_count), 32'd4);
            chk("hold_ready", 32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_rel_valid", 32'(out_valid), 32'd0);
        chk("hold_rel_ready", 32'(in_ready),  32'd1);
        push(4'b0100, 1'b1);
        expect_word("after_hold", 16'h0001, 3'd1, 1'b0);

        // reset mid-word discards the partial digits
        @(negedge clk);
        w0 = words;
        push(4'b0100, 1'b0);
        push(4'b0101, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready),  32'd1);
        push(4'b1000, 1'b0);
        push(4'b1001, 1'b0);
        push(4'b1010, 1'b0);
        push(4'b1011, 1'b0);
        expect_word("w5678", 16'h5678, 3'd4, 1'b0);
        repeat (2) @(negedge clk);
        chk("w5678_once", 32'(words - w0), 32'd1);

        // reset during HOLD drops the pending word
        out_ready = 1'b0;
        push(4'b1100, 1'b1);
        @(negedge clk);
        chk("holdrst_pre", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("holdrst_valid", 32'(out_valid), 32'd0);
        chk("holdrst_bcd",   32'(out_bcd),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("holdrst_ready", 32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, expected completion");
        $fatal(1);
    end

endmodule
